mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction cache (block reads only) and the data cache (block reads and write-backs).
- Sits between both caches and data memory, underneath the IF and MEM pipeline stages.
- Grants one requester at a time, registers that requester's address and data, forwards the memory response, and drives each cache's BUSYWAIT so the pipeline stalls correctly.
- Round-robin between the two caches when both request; a watchdog flags a hung memory.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_watchdog.sv | 38 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter: FSM encodings, grant codes
// and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  // State codes double as the GRANT value, so GRANT is the state register.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SERVE_I = 2'b01,
    ST_SERVE_D = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  // Data cache wins when it is alone or when the instruction cache went last.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input logic last_was_d);
    return d_req && (!i_req || !last_was_d);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating busy-cycle counter with a sticky timeout flag; it only reports a
// hung memory and never aborts the transfer.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic count_en,
  input  logic clear,
  output logic TIMEOUT_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;
  logic             r_err;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (clear) begin
        r_count <= '0;
      end else if (count_en && (r_count != LIMIT)) begin
        r_count <= r_count + 1'b1;
      end
      // Flag rises together with the count reaching the limit.
      if (count_en && !clear && (r_count == LIMIT - 1'b1)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign TIMEOUT_ERR = r_err;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-memory port between the instruction
// cache (reads) and the data cache (reads and write-backs).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [1:0]        GRANT,
  output logic              TIMEOUT_ERR
);

  arb_state_e        r_state;
  logic              r_last_d;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;
  logic w_i_done;
  logic w_d_done;
  logic w_done;
  logic w_busy_cnt;

  // Handshake: a cache holds x_REQ and its address until x_BUSYWAIT is low;
  // the cycle it sees x_BUSYWAIT low is the completion cycle and READDATA is
  // valid then. Memory completes a strobe in the cycle MEM_BUSYWAIT is low.
  assign w_i_req   = I_READ;
  assign w_d_req   = D_READ | D_WRITE;
  assign w_grant_d = pick_d(w_i_req, w_d_req, r_last_d);
  assign w_i_done  = (r_state == ST_SERVE_I) && !MEM_BUSYWAIT;
  assign w_d_done  = (r_state == ST_SERVE_D) && !MEM_BUSYWAIT;
  assign w_done    = w_i_done | w_d_done;
  assign w_busy_cnt = (r_state != ST_IDLE) && MEM_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_last_d    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state     <= ST_SERVE_D;
            r_last_d    <= 1'b1;
            r_mem_addr  <= D_ADDRESS;
            r_mem_wdata <= D_WRITEDATA;
            // Read and write together is a write-back.
            r_mem_write <= D_WRITE;
            r_mem_read  <= !D_WRITE;
          end else if (w_i_req) begin
            r_state     <= ST_SERVE_I;
            r_last_d    <= 1'b0;
            r_mem_addr  <= I_ADDRESS;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (w_done) begin
            r_state     <= ST_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_i_done) r_i_rdata <= MEM_READDATA;
      if (w_d_done) r_d_rdata <= MEM_READDATA;
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK        (CLK),
    .RESET      (RESET),
    .count_en   (w_busy_cnt),
    .clear      (w_done),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  assign I_READDATA    = w_i_done ? MEM_READDATA : r_i_rdata;
  assign D_READDATA    = w_d_done ? MEM_READDATA : r_d_rdata;
  assign I_BUSYWAIT    = w_i_req && !w_i_done;
  assign D_BUSYWAIT    = w_d_req && !w_d_done;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;
  assign GRANT         = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: cache drivers push expectations, a memory
// model answers strobes, and a cycle monitor checks grants, stalls and data.
module tb_mem_arbiter;
  localparam int AW     = 28;
  localparam int DW     = 128;
  localparam int TO     = 8;
  localparam int BUDGET = 200;

  logic          CLK;
  logic          RESET;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ;
  logic          D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [DW-1:0] D_WRITEDATA;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;
  logic [1:0]    GRANT;
  logic          TIMEOUT_ERR;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } tx_t;

  int            n_tests;
  int            n_fail;
  int            force_lat;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  tx_t           exp_i_q[$];
  tx_t           exp_d_q[$];
  logic [2:0]    grant_log[$];

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_blk(input logic [AW-1:0] a);
    return {4{4'hA, a}};
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_blk(a);
  endfunction

  // Round-robin rule: a lone requester wins; a tie goes to whoever did not go last.
  function automatic logic [1:0] arb(input logic ir, input logic dr, input logic [1:0] last);
    if (ir && dr) return (last == 2'd1) ? 2'd2 : 2'd1;
    if (dr) return 2'd2;
    if (ir) return 2'd1;
    return 2'd0;
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    #3 RESET = 1'b0;
    #1;
    check("rst_grant", GRANT, 2'b00);
    check("rst_mem_read", MEM_READ, 1'b0);
    check("rst_mem_write", MEM_WRITE, 1'b0);
    check("rst_mem_addr", MEM_ADDRESS, '0);
    check("rst_mem_wdata", MEM_WRITEDATA, '0);
    check("rst_timeout", TIMEOUT_ERR, 1'b0);
    check("rst_i_rdata", I_READDATA, '0);
    check("rst_d_rdata", D_READDATA, '0);
    repeat (2) @(negedge CLK);
    #4 RESET = 1'b1;
    @(negedge CLK);
  endtask

  // ---------------- drivers (called on a falling edge) ----------------
  task automatic i_read(input logic [AW-1:0] a);
    tx_t t;
    int  k;
    t.wr = 1'b0; t.addr = a; t.data = ref_rd(a);
    exp_i_q.push_back(t);
    I_ADDRESS = a;
    I_READ    = 1'b1;
    for (k = 0; k < BUDGET; k++) begin
      #2;
      if (!I_BUSYWAIT) break;
      @(negedge CLK);
    end
    check("i_wait_budget", k < BUDGET, 1'b1);
    @(negedge CLK);
    I_READ = 1'b0;
  endtask

  task automatic d_op(input logic wr, input logic both, input logic [AW-1:0] a,
                      input logic [DW-1:0] wdata);
    tx_t t;
    int  k;
    t.wr = wr; t.addr = a; t.data = wr ? wdata : ref_rd(a);
    if (wr) ref_mem[a] = wdata;
    exp_d_q.push_back(t);
    D_ADDRESS   = a;
    D_WRITEDATA = wdata;
    D_WRITE     = wr;
    D_READ      = !wr || both;
    for (k = 0; k < BUDGET; k++) begin
      #2;
      if (!D_BUSYWAIT) break;
      @(negedge CLK);
    end
    check("d_wait_budget", k < BUDGET, 1'b1);
    @(negedge CLK);
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
  endtask

  // ---------------- memory model ----------------
  initial begin
    int m_cyc;
    int m_lat;
    m_cyc = 0;
    m_lat = 0;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    forever begin
      @(negedge CLK);
      if (MEM_READ || MEM_WRITE) begin
        if (m_cyc == 0) m_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
        if (m_cyc < m_lat) begin
          MEM_BUSYWAIT = 1'b1;
          MEM_READDATA = {4{$urandom}};
          m_cyc++;
        end else begin
          MEM_BUSYWAIT = 1'b0;
          m_cyc = 0;
          if (MEM_WRITE) begin
            mem_store[MEM_ADDRESS] = MEM_WRITEDATA;
            MEM_READDATA = {4{$urandom}};
          end else begin
            MEM_READDATA = mem_store.exists(MEM_ADDRESS) ? mem_store[MEM_ADDRESS]
                                                         : init_blk(MEM_ADDRESS);
          end
        end
      end else begin
        m_cyc = 0;
        MEM_BUSYWAIT = 1'($urandom_range(0, 1));
        MEM_READDATA = {4{$urandom}};
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [1:0]    m_grant;
    logic [1:0]    m_last;
    logic          m_wr;
    int            m_wd;
    logic          m_to;
    logic [DW-1:0] m_i_hold;
    logic          done;
    tx_t           t;
    m_grant = 2'd0; m_last = 2'd1; m_wr = 1'b0; m_wd = 0; m_to = 1'b0; m_i_hold = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (!RESET) begin
        m_last = 2'd1; m_wd = 0; m_to = 1'b0; m_i_hold = '0;
        m_grant = arb(I_READ, D_READ | D_WRITE, m_last);
        m_wr = D_WRITE;
        if (m_grant != 2'd0) m_last = m_grant;
      end else begin
        done = (m_grant != 2'd0) && !MEM_BUSYWAIT;
        check("grant", GRANT, m_grant);
        check("mem_read", MEM_READ, (m_grant == 2'd1) || (m_grant == 2'd2 && !m_wr));
        check("mem_write", MEM_WRITE, (m_grant == 2'd2) && m_wr);
        check("i_busywait", I_BUSYWAIT, I_READ && !(done && m_grant == 2'd1));
        check("d_busywait", D_BUSYWAIT, (D_READ || D_WRITE) && !(done && m_grant == 2'd2));
        check("timeout_err", TIMEOUT_ERR, m_to);
        if (done && m_grant == 2'd1) begin
          check("i_exp_pending", exp_i_q.size() != 0, 1'b1);
          if (exp_i_q.size() != 0) begin
            t = exp_i_q.pop_front();
            check("i_mem_addr", MEM_ADDRESS, t.addr);
            check("i_readdata", I_READDATA, t.data);
            m_i_hold = t.data;
          end
          grant_log.push_back({MEM_WRITE, GRANT});
        end else begin
          check("i_readdata_hold", I_READDATA, m_i_hold);
        end
        if (done && m_grant == 2'd2) begin
          check("d_exp_pending", exp_d_q.size() != 0, 1'b1);
          if (exp_d_q.size() != 0) begin
            t = exp_d_q.pop_front();
            check("d_mem_addr", MEM_ADDRESS, t.addr);
            check("d_is_write", MEM_WRITE, t.wr);
            if (t.wr) check("d_mem_wdata", MEM_WRITEDATA, t.data);
            else      check("d_readdata", D_READDATA, t.data);
          end
          grant_log.push_back({MEM_WRITE, GRANT});
        end
        if (m_grant != 2'd0) begin
          if (done) m_wd = 0;
          else begin
            if (m_wd < TO) m_wd++;
            if (m_wd == TO) m_to = 1'b1;
          end
        end
        if (m_grant == 2'd0) begin
          m_grant = arb(I_READ, D_READ | D_WRITE, m_last);
          m_wr = D_WRITE;
          if (m_grant != 2'd0) m_last = m_grant;
        end else if (done) begin
          m_grant = 2'd0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    logic          wr;
    int            k;
    n_tests = 0; n_fail = 0; force_lat = -1;
    RESET = 1'b0;
    I_READ = 1'b0; I_ADDRESS = '0;
    D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
    repeat (2) @(negedge CLK);
    check("init_grant", GRANT, 2'b00);
    check("init_mem_read", MEM_READ, 1'b0);
    check("init_mem_write", MEM_WRITE, 1'b0);
    check("init_timeout", TIMEOUT_ERR, 1'b0);
    #4 RESET = 1'b1;
    @(negedge CLK);

    // I-only read, 5-cycle memory latency
    a = 28'h0000010;
    mem_store[a] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    ref_mem[a]   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    force_lat = 5;
    i_read(a);

    // D write-back
    force_lat = 3;
    d_op(1'b1, 1'b0, 28'h0000020, 128'h1111_2222_3333_4444);

    // Simultaneous requests straight from reset: D first, then I
    force_lat = 2;
    apply_reset();
    grant_log.delete();
    fork
      i_read(28'h0000040);
      d_op(1'b0, 1'b0, 28'h1000050, '0);
    join
    check("sim_log_len", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("sim_first_d", grant_log[0], 3'b010);
      check("sim_then_i", grant_log[1], 3'b001);
    end

    // D write then D read with I held: D write, I read, D read
    grant_log.delete();
    fork
      i_read(28'h0000044);
      begin
        d_op(1'b1, 1'b0, 28'h1000060, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC);
        d_op(1'b0, 1'b0, 28'h1000060, '0);
      end
    join
    check("b2b_log_len", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("b2b_d_write", grant_log[0], 3'b110);
      check("b2b_i_read", grant_log[1], 3'b001);
      check("b2b_d_read", grant_log[2], 3'b010);
    end

    // Randomized mixed traffic
    force_lat = -1;
    fork
      begin
        logic [AW-1:0] ia;
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          ia = AW'($urandom_range(0, 63));
          i_read(ia);
        end
      end
      begin
        logic [AW-1:0] da;
        logic          dw;
        logic          both;
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          da   = 28'h1000000 + AW'($urandom_range(0, 15));
          dw   = 1'($urandom_range(0, 1));
          both = dw && 1'($urandom_range(0, 1));
          d_op(dw, both, da, {4{$urandom}});
        end
      end
    join

    // Reset in the middle of a data-cache write; the held request is re-granted
    force_lat = 10;
    grant_log.delete();
    fork
      d_op(1'b1, 1'b0, 28'h1000070, 128'h0BAD_F00D);
      begin
        for (k = 0; k < 50; k++) begin
          @(negedge CLK);
          #3;
          if (GRANT == 2'b10) break;
        end
        check("rmid_granted", GRANT, 2'b10);
        RESET = 1'b0;
        #1;
        check("rmid_mem_write", MEM_WRITE, 1'b0);
        check("rmid_mem_read", MEM_READ, 1'b0);
        check("rmid_grant", GRANT, 2'b00);
        force_lat = 2;
        @(negedge CLK);
        #4 RESET = 1'b1;
      end
    join
    check("rmid_log_len", grant_log.size(), 1);

    // Hung memory: 12 busy cycles trips the 8-cycle watchdog, flag is sticky
    force_lat = 12;
    i_read(28'h0000030);
    force_lat = -1;
    repeat (3) @(negedge CLK);
    #2;
    check("to_sticky", TIMEOUT_ERR, 1'b1);
    apply_reset();
    #2;
    check("to_cleared", TIMEOUT_ERR, 1'b0);

    repeat (4) @(negedge CLK);
    check("i_queue_drained", exp_i_q.size(), 0);
    check("d_queue_drained", exp_d_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
